// File: rtl/store_rmw_ctrl_pkg.sv
// Shared types and helpers for the read-modify-write store controller.
package store_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD1,
      S_WR1,
      S_RD2,
      S_WR2,
      S_DONE
   } state_e;

   // Number of bytes written for a size code; 0 for the illegal code.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         SZ_WORD: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   // True when the bytes starting at lane 'off' spill into the next word.
   function automatic logic crosses(input logic [1:0] off, input logic [2:0] n);
      return (({2'b00, off} + {1'b0, n}) > 4'd4);
   endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// Word-wide memory bus between the store controller and the shared bus.
interface store_bus_if;

   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack;
   logic        err;

   modport master (
      output cyc, stb, we, adr, dat_o,
      input  dat_i, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr, dat_o,
      output dat_i, ack, err
   );

endinterface

// File: rtl/store_rmw_ctrl_merge.sv
// Byte-lane merge of right-justified store data into the two covered words.
module store_merge (
   input  logic [31:0] w0_i,
   input  logic [31:0] w1_i,
   input  logic [31:0] data_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  n_i,
   output logic [31:0] w0_o,
   output logic [31:0] w1_o
);

   // Lanes inside [off, off+n) come from the new data; spill-over lands in w1.
   always_comb begin
      int unsigned off;
      int unsigned lim;
      off  = 32'(off_i);
      lim  = off + 32'(n_i);
      w0_o = w0_i;
      w1_o = w1_i;
      for (int unsigned i = 0; i < 4; i++) begin
         if ((i >= off) && (i < lim)) begin
            w0_o[8*i +: 8] = data_i[8*(i - off) +: 8];
         end
         if ((i + 4) < lim) begin
            w1_o[8*i +: 8] = data_i[8*(4 - off + i) +: 8];
         end
      end
   end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Read-modify-write sequencer for sub-word and unaligned stores on a 32-bit bus.
module store_rmw_ctrl
   import store_pkg::*;
#(
   parameter bit ALLOW_UNALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid_i,
   output logic        st_ready_o,
   input  logic [31:0] st_addr_i,
   input  logic [31:0] st_data_i,
   input  logic [1:0]  st_size_i,
   output logic        st_done_o,
   output logic        st_err_o,
   store_bus_if.master bus
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] w0_q, w0_d;
   logic [31:0] w1_q, w1_d;
   logic        err_q, err_d;

   logic [1:0]  off_q;
   logic [2:0]  n_q;
   logic        cross_q;
   logic [31:0] a0, a1;
   logic [31:0] m0, m1;

   logic [1:0]  off_in;
   logic [2:0]  n_in;
   logic        cross_in;

   assign off_q    = addr_q[1:0];
   assign n_q      = size_bytes(size_q);
   assign cross_q  = crosses(off_q, n_q);
   assign a0       = {addr_q[31:2], 2'b00};
   assign a1       = a0 + 32'd4;

   assign off_in   = st_addr_i[1:0];
   assign n_in     = size_bytes(st_size_i);
   assign cross_in = crosses(off_in, n_in);

   store_merge u_merge (
      .w0_i   (w0_q),
      .w1_i   (w1_q),
      .data_i (data_q),
      .off_i  (off_q),
      .n_i    (n_q),
      .w0_o   (m0),
      .w1_o   (m1)
   );

   // State and request registers; reset drops any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= '0;
         w0_q    <= '0;
         w1_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         size_q  <= size_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         err_q   <= err_d;
      end
   end

   // Next-state and bus/handshake outputs; bus_err beats bus_ack in every phase.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      size_d     = size_q;
      w0_d       = w0_q;
      w1_d       = w1_q;
      err_d      = err_q;
      st_ready_o = 1'b0;
      st_done_o  = 1'b0;
      st_err_o   = 1'b0;
      bus.cyc    = 1'b0;
      bus.stb    = 1'b0;
      bus.we     = 1'b0;
      bus.adr    = '0;
      bus.dat_o  = '0;

      case (state_q)
         S_IDLE: begin
            st_ready_o = 1'b1;
            if (st_valid_i) begin
               addr_d = st_addr_i;
               data_d = st_data_i;
               size_d = st_size_i;
               err_d  = 1'b0;
               if ((st_size_i == SZ_ILL) || (cross_in && !ALLOW_UNALIGNED)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if ((st_size_i == SZ_WORD) && (off_in == 2'd0)) begin
                  state_d = S_WR1;
               end else begin
                  state_d = S_RD1;
               end
            end
         end

         S_RD1: begin
            bus.cyc = 1'b1;
            bus.stb = 1'b1;
            bus.adr = a0;
            if (bus.err) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (bus.ack) begin
               w0_d    = bus.dat_i;
               state_d = S_WR1;
            end
         end

         S_WR1: begin
            bus.cyc   = 1'b1;
            bus.stb   = 1'b1;
            bus.we    = 1'b1;
            bus.adr   = a0;
            bus.dat_o = m0;
            if (bus.err) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (bus.ack) begin
               state_d = cross_q ? S_RD2 : S_DONE;
            end
         end

         S_RD2: begin
            bus.cyc = 1'b1;
            bus.stb = 1'b1;
            bus.adr = a1;
            if (bus.err) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (bus.ack) begin
               w1_d    = bus.dat_i;
               state_d = S_WR2;
            end
         end

         S_WR2: begin
            bus.cyc   = 1'b1;
            bus.stb   = 1'b1;
            bus.we    = 1'b1;
            bus.adr   = a1;
            bus.dat_o = m1;
            if (bus.err) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (bus.ack) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            st_done_o = 1'b1;
            st_err_o  = err_q;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl with a bus memory model and write scoreboard.
module tb_store_rmw_ctrl;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        st_valid, st_ready, st_done, st_err;
   logic [31:0] st_addr, st_data;
   logic [1:0]  st_size;
   logic        na_valid, na_ready, na_done, na_err;
   logic [31:0] na_addr, na_data;
   logic [1:0]  na_size;

   store_bus_if bif ();
   store_bus_if bif_na ();

   store_rmw_ctrl #(.ALLOW_UNALIGNED(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .st_valid_i (st_valid),
      .st_ready_o (st_ready),
      .st_addr_i  (st_addr),
      .st_data_i  (st_data),
      .st_size_i  (st_size),
      .st_done_o  (st_done),
      .st_err_o   (st_err),
      .bus        (bif)
   );

   store_rmw_ctrl #(.ALLOW_UNALIGNED(1'b0)) dut_na (
      .clk        (clk),
      .rst        (rst),
      .st_valid_i (na_valid),
      .st_ready_o (na_ready),
      .st_addr_i  (na_addr),
      .st_data_i  (na_data),
      .st_size_i  (na_size),
      .st_done_o  (na_done),
      .st_err_o   (na_err),
      .bus        (bif_na)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] mem [logic [31:0]];
   wr_t         sb [$];
   int          ws = 0;
   int          err_phase = -1;
   int          phase = 0;
   int          wcnt = 0;
   logic [31:0] prev_adr;
   logic        prev_we;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // Memory model step, evaluated at the falling edge so ack is stable for the DUT.
   task automatic slave_step();
      wr_t e;
      bif.ack   = 1'b0;
      bif.err   = 1'b0;
      bif.dat_i = '0;
      if (rst || !bif.cyc) begin
         wcnt  = 0;
         phase = 0;
      end else if (bif.stb) begin
         if (wcnt > 0) begin
            chk("stb_hold_adr", bif.adr, prev_adr);
            chk("stb_hold_we", 32'(bif.we), 32'(prev_we));
         end
         prev_adr = bif.adr;
         prev_we  = bif.we;
         if (wcnt < ws) begin
            wcnt++;
         end else begin
            wcnt = 0;
            if (phase == err_phase) begin
               bif.err = 1'b1;
            end else begin
               bif.ack = 1'b1;
               if (bif.we) begin
                  mem[bif.adr] = bif.dat_o;
                  chk("sb_expected_write", 32'(sb.size() > 0), 32'd1);
                  if (sb.size() > 0) begin
                     e = sb.pop_front();
                     chk("wr_adr", bif.adr, e.adr);
                     chk("wr_dat", bif.dat_o, e.dat);
                  end
               end else begin
                  bif.dat_i = rd(bif.adr);
               end
            end
            phase++;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      slave_step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.adr = a;
      e.dat = d;
      sb.push_back(e);
   endtask

   task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input int exp_cyc, input logic exp_err);
      int  cyc_n;
      int  cyc_low;
      bit  seen;
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_size  = sz;
      chk({tag, "_ready"}, 32'(st_ready), 32'd1);
      cycle();
      st_valid = 1'b0;
      cyc_n    = 1;
      cyc_low  = 0;
      seen     = 1'b0;
      while (!seen && cyc_n <= 60) begin
         if (st_done) begin
            seen = 1'b1;
            chk({tag, "_done_cycle"}, 32'(cyc_n), 32'(exp_cyc));
            chk({tag, "_err"}, 32'(st_err), 32'(exp_err));
            chk({tag, "_cyc_in_done"}, 32'(bif.cyc), 32'd0);
         end else begin
            if (!bif.cyc) cyc_low++;
            cycle();
            cyc_n++;
         end
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_cyc_gaps"}, 32'(cyc_low), 32'd0);
      chk({tag, "_writes_left"}, 32'(sb.size()), 32'd0);
      cycle();
      chk({tag, "_done_pulse"}, 32'(st_done), 32'd0);
      chk({tag, "_err_idle"}, 32'(st_err), 32'd0);
      chk({tag, "_back_idle"}, 32'(st_ready), 32'd1);
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_done;
      rst        = 1'b1;
      st_valid   = 1'b0;
      st_addr    = '0;
      st_data    = '0;
      st_size    = '0;
      na_valid   = 1'b0;
      na_addr    = '0;
      na_data    = '0;
      na_size    = '0;
      bif.ack    = 1'b0;
      bif.err    = 1'b0;
      bif.dat_i  = '0;
      bif_na.ack = 1'b0;
      bif_na.err = 1'b0;
      bif_na.dat_i = '0;
      prev_adr   = '0;
      prev_we    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(st_ready), 32'd1);
      chk("rst_cyc", 32'(bif.cyc), 32'd0);
      chk("rst_stb", 32'(bif.stb), 32'd0);
      chk("rst_we", 32'(bif.we), 32'd0);
      chk("rst_adr", bif.adr, 32'h0);
      chk("rst_dat_o", bif.dat_o, 32'h0);
      chk("rst_done", 32'(st_done), 32'd0);
      chk("rst_err", 32'(st_err), 32'd0);
      rst = 1'b0;
      cycle();

      // Aligned word: single write, no read.
      mem.delete();
      push_wr(32'h100, 32'hDEADBEEF);
      run_store("aligned_word", 32'h100, 32'hDEADBEEF, 2'd2, 2, 1'b0);

      // Byte store into the middle of a word.
      mem.delete();
      mem[32'h100] = 32'h11223344;
      push_wr(32'h100, 32'h11AB3344);
      run_store("byte_off2", 32'h102, 32'h000000AB, 2'd0, 3, 1'b0);

      // Half store ending exactly at the word boundary does not cross.
      mem.delete();
      mem[32'h100] = 32'h11223344;
      push_wr(32'h100, 32'h55663344);
      run_store("half_off2", 32'h102, 32'h00005566, 2'd1, 3, 1'b0);

      // Byte in the top lane.
      mem.delete();
      mem[32'h200] = 32'h11223344;
      push_wr(32'h200, 32'h99223344);
      run_store("byte_off3", 32'h203, 32'h00000099, 2'd0, 3, 1'b0);

      // Crossing half store.
      mem.delete();
      mem[32'h100] = 32'hFFFFFFFF;
      mem[32'h104] = 32'hFFFFFFFF;
      push_wr(32'h100, 32'hEFFFFFFF);
      push_wr(32'h104, 32'hFFFFFFBE);
      run_store("cross_half", 32'h103, 32'h0000BEEF, 2'd1, 5, 1'b0);

      // Crossing word store wrapping the address space.
      mem.delete();
      push_wr(32'hFFFFFFFC, 32'hFEBABE00);
      push_wr(32'h00000000, 32'h000000CA);
      run_store("cross_wrap", 32'hFFFFFFFD, 32'hCAFEBABE, 2'd2, 5, 1'b0);

      // bus_err on the second read: first word stays written, no second write.
      mem.delete();
      mem[32'h100] = 32'hFFFFFFFF;
      mem[32'h104] = 32'hFFFFFFFF;
      err_phase = 2;
      push_wr(32'h100, 32'hEFFFFFFF);
      run_store("err_rd2", 32'h103, 32'h0000BEEF, 2'd1, 4, 1'b1);
      err_phase = -1;
      chk("err_rd2_w1_kept", rd(32'h104), 32'hFFFFFFFF);
      chk("err_rd2_w0_written", rd(32'h100), 32'hEFFFFFFF);

      // Illegal size: error on accept, no bus traffic.
      mem.delete();
      run_store("size_ill", 32'h100, 32'h12345678, 2'd3, 1, 1'b1);

      // Crossing store with three wait states per phase.
      mem.delete();
      mem[32'h100] = 32'hFFFFFFFF;
      mem[32'h104] = 32'hFFFFFFFF;
      ws = 3;
      push_wr(32'h100, 32'hEFFFFFFF);
      push_wr(32'h104, 32'hFFFFFFBE);
      run_store("cross_wait", 32'h103, 32'h0000BEEF, 2'd1, 17, 1'b0);

      // Reset in the middle of RD1 drops the operation.
      mem.delete();
      mem[32'h200] = 32'h55667788;
      st_valid = 1'b1;
      st_addr  = 32'h201;
      st_data  = 32'h000000EE;
      st_size  = 2'd0;
      cycle();
      st_valid = 1'b0;
      cycle();
      chk("rst_mid_in_rd1", 32'(bif.cyc), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_cyc", 32'(bif.cyc), 32'd0);
      chk("rst_mid_stb", 32'(bif.stb), 32'd0);
      chk("rst_mid_adr", bif.adr, 32'h0);
      chk("rst_mid_done", 32'(st_done), 32'd0);
      chk("rst_mid_ready", 32'(st_ready), 32'd1);
      cycle();
      rst = 1'b0;
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         if (st_done) n_done++;
         cycle();
      end
      chk("rst_mid_no_done", 32'(n_done), 32'd0);
      chk("rst_mid_mem", rd(32'h200), 32'h55667788);
      ws = 0;

      // Disallowed unaligned store on the second instance.
      na_valid = 1'b1;
      na_addr  = 32'h103;
      na_data  = 32'h0000BEEF;
      na_size  = 2'd1;
      chk("na_ready", 32'(na_ready), 32'd1);
      @(posedge clk);
      #1;
      na_valid = 1'b0;
      chk("na_done_c1", 32'(na_done), 32'd1);
      chk("na_err_c1", 32'(na_err), 32'd1);
      chk("na_cyc_c1", 32'(bif_na.cyc), 32'd0);
      @(posedge clk);
      #1;
      chk("na_done_pulse", 32'(na_done), 32'd0);
      chk("na_cyc_c2", 32'(bif_na.cyc), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
